// File: rtl/latch_mem_wb.sv
// MEM/WB pipeline register: 1-cycle capture of write-back controls, ALU result, load data and dst,
// with stall hold and flush bubble. Optional macro LATCH_MEM_WB_WBMUX_EN adds the wb_data select output.
module latch_mem_wb #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  reg_write,
    input  logic                  mem_to_reg,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     data_load,
    input  logic [REG_ADDR_W-1:0] dst,
    output logic                  reg_write_reg,
    output logic                  mem_to_reg_reg,
    output logic [DATA_W-1:0]     alu_result_reg,
    output logic [DATA_W-1:0]     data_load_reg,
`ifdef LATCH_MEM_WB_WBMUX_EN
    output logic [DATA_W-1:0]     wb_data,
`endif
    output logic [REG_ADDR_W-1:0] dst_reg
);

    logic                  r_reg_write;
    logic                  r_mem_to_reg;
    logic [DATA_W-1:0]     r_alu_result;
    logic [DATA_W-1:0]     r_data_load;
    logic [REG_ADDR_W-1:0] r_dst;

    // Reset and flush both load the bubble (no write, dst r0); flush overrides stall.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_result <= '0;
            r_data_load  <= '0;
            r_dst        <= '0;
        end else if (!stall) begin
            r_reg_write  <= reg_write;
            r_mem_to_reg <= mem_to_reg;
            r_alu_result <= alu_result;
            r_data_load  <= data_load;
            r_dst        <= dst;
        end
    end

    assign reg_write_reg  = r_reg_write;
    assign mem_to_reg_reg = r_mem_to_reg;
    assign alu_result_reg = r_alu_result;
    assign data_load_reg  = r_data_load;
    assign dst_reg        = r_dst;

`ifdef LATCH_MEM_WB_WBMUX_EN
    logic [DATA_W-1:0] w_wb_data;
    assign w_wb_data = r_mem_to_reg ? r_data_load : r_alu_result;
    assign wb_data   = w_wb_data;
`endif

endmodule

// File: tb/tb_latch_mem_wb.sv
// Self-checking bench for latch_mem_wb: directed scenarios then randomized cycles
// compared against a behavioural model of the pipeline register.
module tb_latch_mem_wb;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n, stall, flush, reg_write, mem_to_reg;
    logic [DW-1:0] alu_result, data_load;
    logic [AW-1:0] dst;
    logic          reg_write_reg, mem_to_reg_reg;
    logic [DW-1:0] alu_result_reg, data_load_reg;
    logic [AW-1:0] dst_reg;
`ifdef LATCH_MEM_WB_WBMUX_EN
    logic [DW-1:0] wb_data;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model of what WB should see this cycle.
    typedef struct {
        logic          rw;
        logic          m2r;
        logic [DW-1:0] alu;
        logic [DW-1:0] dl;
        logic [AW-1:0] dst;
    } wb_t;
    wb_t m;

    latch_mem_wb #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .reg_write      (reg_write),
        .mem_to_reg     (mem_to_reg),
        .alu_result     (alu_result),
        .data_load      (data_load),
        .dst            (dst),
        .reg_write_reg  (reg_write_reg),
        .mem_to_reg_reg (mem_to_reg_reg),
        .alu_result_reg (alu_result_reg),
        .data_load_reg  (data_load_reg),
`ifdef LATCH_MEM_WB_WBMUX_EN
        .wb_data        (wb_data),
`endif
        .dst_reg        (dst_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".reg_write"},  {31'd0, reg_write_reg},  {31'd0, m.rw});
        chk({tag, ".mem_to_reg"}, {31'd0, mem_to_reg_reg}, {31'd0, m.m2r});
        chk({tag, ".alu_result"}, alu_result_reg,          m.alu);
        chk({tag, ".data_load"},  data_load_reg,           m.dl);
        chk({tag, ".dst"},        {27'd0, dst_reg},        {27'd0, m.dst});
`ifdef LATCH_MEM_WB_WBMUX_EN
        chk({tag, ".wb_data"},    wb_data,                 m.m2r ? m.dl : m.alu);
`endif
    endtask

    task automatic drive(input logic rn, input logic fl, input logic st, input logic rw,
                         input logic m2r, input logic [DW-1:0] alu, input logic [DW-1:0] dl,
                         input logic [AW-1:0] d);
        rst_n = rn; flush = fl; stall = st; reg_write = rw; mem_to_reg = m2r;
        alu_result = alu; data_load = dl; dst = d;
    endtask

    // One clock: the model applies reset > flush > stall > load, then outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n || flush) begin
            m.rw = 1'b0; m.m2r = 1'b0; m.alu = '0; m.dl = '0; m.dst = '0;
        end else if (!stall) begin
            m.rw = reg_write; m.m2r = mem_to_reg; m.alu = alu_result; m.dl = data_load; m.dst = dst;
        end
        @(negedge clk);
    endtask

    initial begin
        m = '{rw: 1'bx, m2r: 1'bx, alu: 'x, dl: 'x, dst: 'x};
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);

        // Reset with all-ones inputs
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, '1, '1, '1);
        tick();
        check_all("reset");

        // Load ones, then inputs drop mid-cycle: outputs must hold until the edge
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd1, 32'd1, 5'd1);
        tick();
        check_all("load1");
        chk("load1.alu_const", alu_result_reg, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        #2;
        check_all("load1_hold");
        tick();
        check_all("load0");

        // Stall holds for three edges, release loads zeros
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, '0, 5'd31);
        tick();
        check_all("stall_load");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("stall_hold");
            chk("stall_hold.alu_const", alu_result_reg, 32'hDEADBEEF);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        check_all("stall_release");

        // Flush with stall: bubble wins
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 32'h66, 5'd9);
        tick();
        check_all("pre_flush");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234, '0, 5'd7);
        tick();
        check_all("flush");
        chk("flush.dst_const", {27'd0, dst_reg}, 32'd0);

`ifdef LATCH_MEM_WB_WBMUX_EN
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA, 32'hB, 5'd3);
        tick();
        chk("wbmux_alu", wb_data, 32'hA);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 32'hB, 5'd3);
        tick();
        chk("wbmux_load", wb_data, 32'hB);
`endif

        // Reset asserted while stalled over nonzero state
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE, 32'hF00D, 5'd17);
        tick();
        check_all("pre_rst_stall");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 5'd3);
        tick();
        check_all("rst_stall");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, 5'($urandom));
            tick();
            check_all("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
